// File: rtl/fft_pkg.sv
// Shared types and constant helpers for the radix-2 FFT stage pipeline:
// twiddle generation, butterfly mode selection and lane slicing.
package fft_pkg;

  localparam int FFT_N   = 3;
  localparam int FFT_W   = 2 ** FFT_N;
  localparam int FFT_PTS = 8;

  typedef enum int {TW_ONE, TW_NEGJ, TW_MULT} tw_mode_e;

  // c = cos, s = -sin, both Q2.(W-2)
  typedef struct packed {
    logic signed [31:0] c;
    logic signed [31:0] s;
  } twid_t;

  function automatic int fft_rnd(input int w);
    return 2 ** (w - 3);
  endfunction

  localparam int FFT_RND = fft_rnd(FFT_W);

  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

  function automatic tw_mode_e tw_mode(input int t, input int pts);
    if (t == 0)            return TW_ONE;
    else if (t == pts / 4) return TW_NEGJ;
    else                   return TW_MULT;
  endfunction

  // Elaboration-time only: rounds exp(-j2*pi*t/pts) to nearest Q2.(w-2).
  function automatic twid_t twiddle(input int t, input int pts, input int w);
    real ang, one;
    twid_t r;
    ang  = 2.0 * 3.14159265358979 * t / pts;
    one  = real'(2 ** (w - 2));
    r.c  = $rtoi($floor(one * $cos(ang) + 0.5));
    r.s  = $rtoi($floor(-one * $sin(ang) + 0.5));
    return r;
  endfunction

endpackage

// File: rtl/fft_stage_pipe_if.sv
// Frame handshake bundle between FFT stages: input frame, output frame,
// valid/ready on each side and the sticky overflow flag.
interface fft_stage_pipe_if #(
  parameter int W   = 8,
  parameter int PTS = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [PTS*W-1:0] in_r;
  logic [PTS*W-1:0] in_i;
  logic             out_valid;
  logic             out_ready;
  logic [PTS*W-1:0] out_r;
  logic [PTS*W-1:0] out_i;
  logic             ovf;

  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_r, out_i, ovf
  );

  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out_r, out_i, ovf
  );
endinterface

// File: rtl/fft_bfly_pipe.sv
// Two-register complex butterfly with a fixed twiddle.
// FFT_STAGE_SCALE_EN: halve every sum (round half up) and never flag overflow.
module fft_bfly_pipe
  import fft_pkg::*;
#(
  parameter int       W    = 8,
  parameter tw_mode_e MODE = TW_ONE,
  parameter int       TC   = 0,
  parameter int       TS   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic signed [W-1:0] a_r_i,
  input  logic signed [W-1:0] a_i_i,
  input  logic signed [W-1:0] b_r_i,
  input  logic signed [W-1:0] b_i_i,
  output logic        [W-1:0] y0_r_o,
  output logic        [W-1:0] y0_i_o,
  output logic        [W-1:0] y1_r_o,
  output logic        [W-1:0] y1_i_o,
  output logic                ovf_o
);
  localparam logic signed [W-1:0] C   = W'(TC);
  localparam logic signed [W-1:0] S   = W'(TS);
  localparam logic signed [2*W:0] RND = (2*W+1)'(fft_rnd(W));

  logic signed [W-1:0] a_r_q, a_i_q, nbr;
  logic signed [W:0]   wb_r_d, wb_i_d, wb_r_q, wb_i_q;
  logic signed [2*W:0] pr, pi;
  logic        [W:0]   s0_r, s0_i, s1_r, s1_i;
  logic        [W-1:0] y0_r_q, y0_i_q, y1_r_q, y1_i_q;

  always_comb begin
    pr  = b_r_i * C - b_i_i * S + RND;
    pi  = b_r_i * S + b_i_i * C + RND;
    nbr = -b_r_i;
    case (MODE)
      TW_ONE: begin
        wb_r_d = {b_r_i[W-1], b_r_i};
        wb_i_d = {b_i_i[W-1], b_i_i};
      end
      TW_NEGJ: begin
        // -j*b; -b_r wraps at W bits so -min stays -min
        wb_r_d = {b_i_i[W-1], b_i_i};
        wb_i_d = {nbr[W-1], nbr};
      end
      default: begin
        wb_r_d = (W+1)'(pr >>> (W - 2));
        wb_i_d = (W+1)'(pi >>> (W - 2));
      end
    endcase
  end

  assign s0_r = {a_r_q[W-1], a_r_q} + wb_r_q;
  assign s0_i = {a_i_q[W-1], a_i_q} + wb_i_q;
  assign s1_r = {a_r_q[W-1], a_r_q} - wb_r_q;
  assign s1_i = {a_i_q[W-1], a_i_q} - wb_i_q;

`ifdef FFT_STAGE_SCALE_EN
  function automatic logic [W-1:0] red(input logic [W:0] s);
    logic [W:0] t;
    t = s + (W+1)'(1);
    return t[W:1];
  endfunction
  assign ovf_o = 1'b0;
`else
  function automatic logic [W-1:0] red(input logic [W:0] s);
    return s[W-1:0];
  endfunction
  assign ovf_o = (s0_r[W] ^ s0_r[W-1]) | (s0_i[W] ^ s0_i[W-1]) |
                 (s1_r[W] ^ s1_r[W-1]) | (s1_i[W] ^ s1_i[W-1]);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r_q  <= '0;
      a_i_q  <= '0;
      wb_r_q <= '0;
      wb_i_q <= '0;
      y0_r_q <= '0;
      y0_i_q <= '0;
      y1_r_q <= '0;
      y1_i_q <= '0;
    end else if (en_i) begin
      a_r_q  <= a_r_i;
      a_i_q  <= a_i_i;
      wb_r_q <= wb_r_d;
      wb_i_q <= wb_i_d;
      y0_r_q <= red(s0_r);
      y0_i_q <= red(s0_i);
      y1_r_q <= red(s1_r);
      y1_i_q <= red(s1_i);
    end
  end

  assign y0_r_o = y0_r_q;
  assign y0_i_o = y0_i_q;
  assign y1_r_o = y1_r_q;
  assign y1_i_o = y1_i_q;
endmodule

// File: rtl/fft_stage_pipe.sv
// One pipelined radix-2 DIT stage over a 2**LOG2_PTS-point complex frame.
// Owns the valid pipe, the shared advance enable and the sticky overflow.
module fft_stage_pipe
  import fft_pkg::*;
#(
  parameter int N        = 3,
  parameter int LOG2_PTS = 3,
  parameter int STAGE    = 1
) (
  input  logic            clk,
  input  logic            rst,
  fft_stage_pipe_if.slave bus
);
  localparam int W   = 2 ** N;
  localparam int PTS = 2 ** LOG2_PTS;
  localparam int H   = 2 ** STAGE;
  localparam int NB  = PTS / 2;

  logic          en;
  logic [1:0]    vld_q;
  logic          ovf_q;
  logic [NB-1:0] bf_ovf;

  // Whole pipe stalls together so out_* holds while the sink refuses it.
  assign en            = !vld_q[1] || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_q[1];
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      vld_q <= {vld_q[0], bus.in_valid};
      if (vld_q[0] && |bf_ovf) ovf_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_bfly
    localparam int       I  = (g / H) * 2 * H + (g % H);
    localparam int       T  = (I % H) * (PTS / (2 * H));
    localparam twid_t    TW = twiddle(T, PTS, W);
    localparam tw_mode_e M  = tw_mode(T, PTS);
    localparam int       LA = lane_lo(I, W);
    localparam int       LB = lane_lo(I + H, W);

    fft_bfly_pipe #(
      .W   (W),
      .MODE(M),
      .TC  (int'(TW.c)),
      .TS  (int'(TW.s))
    ) u_bfly (
      .clk   (clk),
      .rst   (rst),
      .en_i  (en),
      .a_r_i (bus.in_r[LA +: W]),
      .a_i_i (bus.in_i[LA +: W]),
      .b_r_i (bus.in_r[LB +: W]),
      .b_i_i (bus.in_i[LB +: W]),
      .y0_r_o(bus.out_r[LA +: W]),
      .y0_i_o(bus.out_i[LA +: W]),
      .y1_r_o(bus.out_r[LB +: W]),
      .y1_i_o(bus.out_i[LB +: W]),
      .ovf_o (bf_ovf[g])
    );
  end
endmodule
